// File: rtl/row_result_serializer_if.sv
// Row-result bundle: three parallel row words in, one serialized word stream out.
interface row_result_serializer_if #(
    parameter int IO_DATA_WIDTH = 16
);
    logic [IO_DATA_WIDTH-1:0] in_1;
    logic [IO_DATA_WIDTH-1:0] in_2;
    logic [IO_DATA_WIDTH-1:0] in_3;
    logic                     load;
    logic                     load_ready;
    logic [IO_DATA_WIDTH-1:0] out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     busy;

    modport master (
        output in_1, in_2, in_3, load, out_ready,
        input  load_ready, out, out_valid, out_last, busy
    );

    modport slave (
        input  in_1, in_2, in_3, load, out_ready,
        output load_ready, out, out_valid, out_last, busy
    );
endinterface

// File: rtl/row_result_serializer.sv
// Gathers one word per PE row into a 3-word group and emits it row 1 first.
// Capture bank A refills while send bank B drains, so groups stream without gaps.
module row_result_serializer #(
    parameter int IO_DATA_WIDTH = 16
) (
    input logic                    clk,
    input logic                    arst_in,
    row_result_serializer_if.slave bus
);
    logic [IO_DATA_WIDTH-1:0] a_p0 [3];
    logic [IO_DATA_WIDTH-1:0] b_p1 [3];
    logic                     a_full;
    logic                     b_full;
    logic [1:0]               idx;

    logic                     hs;
    logic                     last_hs;
    logic                     xfer;
    logic [IO_DATA_WIDTH-1:0] word;

    assign hs      = b_full && bus.out_ready;
    assign last_hs = hs && (idx == 2'd2);
    // A hands over when B is idle or is finishing its last word this very edge.
    assign xfer    = a_full && (!b_full || last_hs);

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
            idx    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                a_p0[i] <= '0;
                b_p1[i] <= '0;
            end
        end else begin
            // capture stage: load_ready is !a_full, so a capture never collides with xfer
            if (bus.load && !a_full) begin
                a_p0[0] <= bus.in_1;
                a_p0[1] <= bus.in_2;
                a_p0[2] <= bus.in_3;
                a_full  <= 1'b1;
            end
            // send stage
            if (xfer) begin
                for (int i = 0; i < 3; i++) begin
                    b_p1[i] <= a_p0[i];
                end
                b_full <= 1'b1;
                idx    <= 2'd0;
                a_full <= 1'b0;
            end else if (hs) begin
                if (idx == 2'd2) begin
                    idx    <= 2'd0;
                    b_full <= 1'b0;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

    always_comb begin
        word = '0;
        if (b_full) begin
            case (idx)
                2'd0:    word = b_p1[0];
                2'd1:    word = b_p1[1];
                2'd2:    word = b_p1[2];
                default: word = '0;
            endcase
        end
    end

    assign bus.out        = word;
    assign bus.out_valid  = b_full;
    assign bus.out_last   = b_full && (idx == 2'd2);
    assign bus.load_ready = !a_full;
    assign bus.busy       = a_full || b_full;
endmodule

// File: tb/tb_row_result_serializer.sv
// Randomized and directed bench for row_result_serializer against a group-queue model.
module tb_row_result_serializer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic arst_in;
    always #5 clk = ~clk;

    row_result_serializer_if #(.IO_DATA_WIDTH(W)) bus ();

    row_result_serializer #(.IO_DATA_WIDTH(W)) dut (
        .clk     (clk),
        .arst_in (arst_in),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int stepn  = 0;

    // Model: at most one waiting group plus the group being sent.
    logic [3*W-1:0] m_pend [$];
    logic [3*W-1:0] m_cur;
    int             m_pos;
    bit             m_send;
    logic [W-1:0]   exp_q  [$];

    logic [W-1:0]   seen_w [$];
    int             seen_t [$];
    bit             seen_l [$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_word();
        logic [W-1:0] w;
        w = '0;
        if (m_send) w = m_cur[(2 - m_pos) * W +: W];
        return w;
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_cur  = '0;
        m_pos  = 0;
        m_send = 0;
    endtask

    task automatic model_update(input logic ld, input logic [3*W-1:0] g, input logic rdy, output bit acc);
        acc = ld && (m_pend.size() == 0);
        if (m_send && rdy) begin
            if (m_pos == 2) m_send = 0;
            else            m_pos++;
        end
        if (!m_send && m_pend.size() > 0) begin
            m_cur  = m_pend.pop_front();
            m_pos  = 0;
            m_send = 1;
        end
        if (acc) begin
            m_pend.push_back(g);
            for (int k = 0; k < 3; k++) exp_q.push_back(g[(2 - k) * W +: W]);
        end
    endtask

    task automatic step(input logic ld, input logic [3*W-1:0] g, input logic rdy, output bit acc);
        bus.load      = ld;
        bus.in_1      = g[3*W-1:2*W];
        bus.in_2      = g[2*W-1:W];
        bus.in_3      = g[W-1:0];
        bus.out_ready = rdy;
        @(negedge clk);
        check_val("out_valid",  bus.out_valid,  m_send);
        check_val("out",        bus.out,        m_word());
        check_val("out_last",   bus.out_last,   m_send && m_pos == 2);
        check_val("load_ready", bus.load_ready, m_pend.size() == 0);
        check_val("busy",       bus.busy,       m_send || m_pend.size() > 0);
        if (bus.out_valid && rdy) begin
            seen_w.push_back(bus.out);
            seen_t.push_back(stepn);
            seen_l.push_back(bus.out_last);
        end
        stepn++;
        @(posedge clk);
        model_update(ld, g, rdy, acc);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, '0, rdy, acc);
    endtask

    task automatic load_group(input logic [3*W-1:0] g, input logic rdy);
        bit acc;
        acc = 0;
        for (int k = 0; k < 10 && !acc; k++) step(1'b1, g, rdy, acc);
        check_val("load_accepted", acc, 1);
    endtask

    task automatic clear_seen();
        seen_w.delete();
        seen_t.delete();
        seen_l.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"},  bus.out_valid,  0);
        check_val({tag, "_out"},        bus.out,        0);
        check_val({tag, "_out_last"},   bus.out_last,   0);
        check_val({tag, "_load_ready"}, bus.load_ready, 1);
        check_val({tag, "_busy"},       bus.busy,       0);
    endtask

    initial begin
        logic [3*W-1:0] grp [3];
        logic [3*W-1:0] g1, g2;
        bit             acc;
        int             s0;

        arst_in       = 1'b0;
        bus.load      = 1'b0;
        bus.in_1      = '0;
        bus.in_2      = '0;
        bus.in_3      = '0;
        bus.out_ready = 1'b0;
        #2;
        arst_in = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_in = 1'b0;

        // Single group
        clear_seen();
        s0 = stepn;
        step(1'b1, {16'h0011, 16'h0022, 16'h0033}, 1'b1, acc);
        idle(5, 1'b1);
        check_val("t1_count", seen_w.size(), 3);
        if (seen_w.size() == 3) begin
            check_val("t1_latency", seen_t[0] - s0, 2);
            check_val("t1_w0", seen_w[0], 16'h0011);
            check_val("t1_w1", seen_w[1], 16'h0022);
            check_val("t1_w2", seen_w[2], 16'h0033);
            check_val("t1_gap", seen_t[2] - seen_t[0], 2);
            check_val("t1_last", {seen_l[0], seen_l[1], seen_l[2]}, 3'b001);
        end
        check_val("t1_idle_busy", bus.busy, 0);

        // Back-pressure
        clear_seen();
        step(1'b1, {16'h0011, 16'h0022, 16'h0033}, 1'b0, acc);
        idle(1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check_val("t2_stall_out", bus.out, 16'h0011);
            check_val("t2_stall_valid", bus.out_valid, 1);
            idle(1, 1'b0);
        end
        idle(4, 1'b1);
        check_val("t2_count", seen_w.size(), 3);
        if (seen_w.size() == 3) begin
            check_val("t2_w0", seen_w[0], 16'h0011);
            check_val("t2_w1", seen_w[1], 16'h0022);
            check_val("t2_w2", seen_w[2], 16'h0033);
        end

        // Streaming three groups
        clear_seen();
        grp[0] = {16'd1, 16'd2, 16'd3};
        grp[1] = {16'd4, 16'd5, 16'd6};
        grp[2] = {16'd7, 16'd8, 16'd9};
        for (int gi = 0; gi < 3; gi++) load_group(grp[gi], 1'b1);
        idle(6, 1'b1);
        check_val("t3_count", seen_w.size(), 9);
        if (seen_w.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                check_val("t3_word", seen_w[k], k + 1);
                check_val("t3_last", seen_l[k], (k % 3) == 2);
            end
            check_val("t3_no_gaps", seen_t[8] - seen_t[0], 8);
        end

        // Overflow attempt
        clear_seen();
        g1 = {16'h1111, 16'h1212, 16'h1313};
        g2 = {16'h2121, 16'h2222, 16'h2323};
        load_group(g1, 1'b0);
        load_group(g2, 1'b0);
        idle(1, 1'b0);
        check_val("t4_load_ready", bus.load_ready, 0);
        check_val("t4_busy", bus.busy, 1);
        step(1'b1, {16'hAAAA, 16'hBBBB, 16'hCCCC}, 1'b0, acc);
        step(1'b1, {16'hAAAA, 16'hBBBB, 16'hCCCC}, 1'b0, acc);
        idle(10, 1'b1);
        check_val("t4_count", seen_w.size(), 6);
        if (seen_w.size() == 6) begin
            for (int k = 0; k < 3; k++) begin
                check_val("t4_g1", seen_w[k],     g1[(2 - k) * W +: W]);
                check_val("t4_g2", seen_w[k + 3], g2[(2 - k) * W +: W]);
            end
        end

        // Reset mid-operation: idx = 1, A full
        clear_seen();
        load_group(g1, 1'b0);
        idle(1, 1'b0);
        load_group(g2, 1'b0);
        idle(1, 1'b1);
        check_val("t5_pre_busy", bus.busy, 1);
        check_val("t5_pre_out", bus.out, 16'h1212);
        arst_in = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("t5_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_in = 1'b0;
        clear_seen();
        idle(6, 1'b1);
        check_val("t5_post_count", seen_w.size(), 0);

        // Last handshake coincides with A->B transfer
        clear_seen();
        load_group(g1, 1'b0);
        idle(1, 1'b0);
        load_group(g2, 1'b0);
        idle(2, 1'b1);
        check_val("t6_pre_last", bus.out_last, 1);
        idle(1, 1'b1);
        check_val("t6_valid", bus.out_valid, 1);
        check_val("t6_out", bus.out, 16'h2121);
        check_val("t6_load_ready", bus.load_ready, 1);
        check_val("t6_out_last", bus.out_last, 0);
        idle(4, 1'b1);

        // Randomized traffic
        clear_seen();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)),
                 {16'($urandom), 16'($urandom), 16'($urandom)},
                 1'($urandom_range(0, 3) != 0), acc);
        end
        idle(12, 1'b1);
        check_val("rand_count", seen_w.size(), exp_q.size());
        if (seen_w.size() == exp_q.size()) begin
            for (int k = 0; k < seen_w.size(); k++) check_val("rand_order", seen_w[k], exp_q[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
